alu_bist: RTL and testbench

Built-in self-test sequencer for the 64-bit ALU: the driving end of the ALU's operand/flag interface. On `start`, it generates pseudo-random operand pairs from an LFSR and applies them across the six ALU operations. It compresses each result and its flags into a 64-bit MISR signature, then reports pass/fail against a golden signature. It sits beside the datapath ALU and drives the ALU's A/B/cntrl inputs through a test mux during power-on or scan test.

---
 rtl/alu_bist.sv | 138 +++++++++++++
 tb/tb_alu_bist.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven ALU self-test with MISR signature compression
//   clk, reset_n             : clock, async active-low reset
//   start, golden            : run request, expected final signature
//   alu_A, alu_B, alu_cntrl  : operands and op driven to the ALU
//   alu_result, alu_*flags   : ALU response compressed into the MISR
//   busy, done, pass         : run status, pass valid while done
//   signature                : current MISR value
module alu_bist #(
    parameter int          N_VECTORS     = 100,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [63:0] SEED          = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] golden,
    output logic [63:0] alu_A,
    output logic [63:0] alu_B,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [63:0] signature
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, DONE} state_t;

    function automatic logic [63:0] step(input logic [63:0] x);
        return {x[62:0], 1'b0} ^ (x[63] ? 64'h1B : 64'h0);
    endfunction

    state_t      state_q, state_d;
    logic [63:0] lfsr_q, lfsr_d, sig_q, sig_d, a_q, a_d, b_q, b_d;
    logic [31:0] vcnt_q, vcnt_d, wcnt_q, wcnt_d;
    logic [2:0]  op_q, op_d, cntrl_q, cntrl_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, arith;

    // overflow/carry only mean something for the op actually applied
    assign arith = (cntrl_q == 3'b010) || (cntrl_q == 3'b011);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        a_d     = a_q;
        b_d     = b_q;
        vcnt_d  = vcnt_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        cntrl_d = cntrl_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = LOAD;
                lfsr_d  = SEED;
                sig_d   = '0;
                op_d    = 3'b000;
                vcnt_d  = '0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
            LOAD: begin
                a_d     = lfsr_q;
                b_d     = step(lfsr_q);
                lfsr_d  = step(step(lfsr_q));
                cntrl_d = op_q;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                state_d = (wcnt_q == 32'(SETTLE_CYCLES - 1)) ? CAPTURE : WAIT;
                wcnt_d  = wcnt_q + 32'd1;
            end
            CAPTURE: begin
                sig_d = step(sig_q) ^ alu_result ^ {60'b0, alu_negative, alu_zero,
                        alu_overflow & arith, alu_carry_out & arith};
                if (vcnt_q < 32'(N_VECTORS - 1)) begin
                    vcnt_d  = vcnt_q + 32'd1;
                    state_d = LOAD;
                end else if (op_q != 3'b110) begin
                    // op order skips the unused 001 encoding
                    vcnt_d  = '0;
                    op_d    = (op_q == 3'b000) ? 3'b010 : op_q + 3'd1;
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (sig_d == golden);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == WAIT) || (state_d == CAPTURE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            sig_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vcnt_q  <= '0;
            wcnt_q  <= '0;
            op_q    <= 3'b000;
            cntrl_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vcnt_q  <= vcnt_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            cntrl_q <= cntrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_cntrl = cntrl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: scoreboard bench for alu_bist with a behavioural ALU in several fault modes
module tb_alu_bist;
    localparam int          N    = 100;
    localparam int          S    = 1;
    localparam logic [63:0] SEED = 64'h1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] golden = '0;
    logic [63:0] alu_A, alu_B, alu_result, signature;
    logic [2:0]  alu_cntrl;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic        busy, done, pass;
    int          mode = 0;
    int          total = 0;
    int          bad = 0;
    logic [130:0] oq[$];

    always #5 clk = ~clk;

    alu_bist #(.N_VECTORS(N), .SETTLE_CYCLES(S), .SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .golden(golden),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    function automatic logic [63:0] tstep(input logic [63:0] x);
        return {x[62:0], 1'b0} ^ (x[63] ? 64'h1B : 64'h0);
    endfunction

    // modes: 0 all zero, 1 ov/co on non-arith ops, 2 ov/co on ADD, 3 real, 4 real with result[17] stuck-at-0
    function automatic logic [67:0] alu_fn(input logic [63:0] a, b, input logic [2:0] c, input int m);
        logic [64:0] s;
        logic [63:0] r;
        logic n, z, ov, co;
        r = '0; ov = 1'b0; co = 1'b0; s = '0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b}; r = s[63:0]; co = s[64];
                ov = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1; r = s[63:0]; co = s[64];
                ov = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        if (m == 4) r[17] = 1'b0;
        n = r[63]; z = (r == 0);
        if (m < 3) begin
            r = '0; n = 1'b0; z = 1'b0;
            ov = (m == 1) ? !(c == 3'b010 || c == 3'b011) : (m == 2) ? (c == 3'b010) : 1'b0;
            co = ov;
        end
        return {n, z, ov, co, r};
    endfunction

    assign {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} = alu_fn(alu_A, alu_B, alu_cntrl, mode);

    task automatic chk(input string tag, input logic [130:0] got, input logic [130:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_sig(input int m);
        logic [63:0] l, a, b, sg;
        logic [67:0] f;
        logic [2:0] ops[6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        logic ar;
        l = SEED; sg = '0;
        for (int o = 0; o < 6; o++)
            for (int v = 0; v < N; v++) begin
                a = l; b = tstep(l); l = tstep(b);
                f = alu_fn(a, b, ops[o], m);
                ar = (ops[o] == 3'b010) || (ops[o] == 3'b011);
                sg = tstep(sg) ^ f[63:0] ^ {60'b0, f[67], f[66], f[65] & ar, f[64] & ar};
            end
        return sg;
    endfunction

    task automatic run(input int m, input logic [63:0] g, input bit poke, input int abort_v);
        logic [63:0] l, a, b, es;
        logic [2:0] ops[6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        logic [63:0] ca[3] = '{64'h1, 64'h4, 64'h10};
        logic [63:0] cb[3] = '{64'h2, 64'h8, 64'h20};
        logic [130:0] e;
        mode = m; golden = g;
        l = SEED;
        for (int o = 0; o < 6; o++)
            for (int v = 0; v < N; v++) begin
                a = l; b = tstep(l); l = tstep(b);
                oq.push_back({ops[o], a, b});
            end
        es = ref_sig(m);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", {busy, done, signature}, {1'b1, 1'b0, 64'h0});
        for (int j = 0; j < 6 * N; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j > 0) repeat (S + 1) @(negedge clk);
            e = oq.pop_front();
            chk("operands", {alu_cntrl, alu_A, alu_B}, e);
            if (j < 3) chk("vec_const", {alu_A, alu_B}, {ca[j], cb[j]});
            if (poke && j == 10) start = 1'b1;
            if (j == abort_v) begin
                #3 reset_n = 1'b0;
                #1 chk("abort_ab", {alu_A, alu_B}, '0);
                chk("abort_misc", {alu_cntrl, busy, done, pass, signature}, '0);
                @(negedge clk); reset_n = 1'b1;
                oq.delete();
                return;
            end
        end
        @(negedge clk);
        chk("pre_done", {busy, done}, 2'b10);
        @(negedge clk);
        chk("done", {busy, done}, 2'b01);
        chk("signature", signature, es);
        chk("pass", pass, (es == g));
        if (m < 2) chk("sig_zero", signature, 0);
        if (m == 2) chk("sig_nonzero", signature != 0, 1);
    endtask

    logic [63:0] real_sig;

    initial begin
        #12;
        chk("reset_ab", {alu_A, alu_B}, '0);
        chk("reset_misc", {alu_cntrl, busy, done, pass, signature}, '0);
        @(negedge clk); reset_n = 1'b1;
        real_sig = ref_sig(3);
        run(0, 64'h0, 0, -1);
        run(0, 64'h1, 0, -1);
        run(1, 64'h0, 0, -1);
        run(2, 64'h0, 0, -1);
        run(3, real_sig, 0, -1);
        run(4, real_sig, 0, -1);
        run(3, real_sig, 0, 50);
        run(3, real_sig, 0, -1);
        run(3, real_sig, 1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
